// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide ripple slice is reused WIDTH/DIGIT times,
// with a registered carry between digits and valid/ready handshakes on both sides.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             c_msb,
  output logic             cout
);
  // Each bit's carry-in is taken from the previous bit's block, giving a plain ripple chain.
  for (genvar g = 0; g < DIGIT; g++) begin : g_bit
    logic ci;
    logic co;
    if (g == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_bit[g-1].co;
    end
    serial_adder_fa u_fa (
      .a  (a[g]),
      .b  (b[g]),
      .ci (ci),
      .s  (s[g]),
      .co (co)
    );
  end

  assign c_msb = g_bit[DIGIT-1].ci;
  assign cout  = g_bit[DIGIT-1].co;
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_msb, c_dig;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_dig),
    .b     (b_dig),
    .cin   (carry_q),
    .s     (s_dig),
    .c_msb (c_msb),
    .cout  (c_dig)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is folded in here: invert B and the carry once, then always add.
          a_d     = A;
          b_d     = B ^ {WIDTH{Sub}};
          carry_d = C_in ^ Sub;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) sum_d[i*DIGIT +: DIGIT] = s_dig;
        end
        carry_d = c_dig;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          c_out_d = c_dig;
          ovf_d   = c_msb ^ c_dig;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign C_out     = c_out_q;
  assign Overflow  = ovf_q;
endmodule
